inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, 2..16).
REQ-002 SHALL have parameter PTR_W, default 2, log2(DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port flush_i  input  1  branch/exception flush from later stages.
REQ-006 SHALL have port if_valid_i  input  1  IF stage offers an instruction.
REQ-007 SHALL have port if_pc_i  input  32  PC of offered instruction.
REQ-008 SHALL have port if_inst_i  input  32  instruction word.
REQ-009 SHALL have port if_excp_i  input  7  {excp flag, 6-bit ecode} raised at fetch.
REQ-010 SHALL have port if_allowin_o  output  1  queue accepts an entry this cycle.
REQ-011 SHALL have port id_valid_o  output  1  head entry presented to decode.
REQ-012 SHALL have port id_allowin_i  input  1  decode consumes head this cycle.
REQ-013 SHALL have port id_pc_o  output  32, id_inst_o  output  32, id_excp_o  output  7  head entry fields.
REQ-014 SHALL have port count_o  output  PTR_W+1  current occupancy.

Function
REQ-015 Push SHALL occur when if_valid_i && if_allowin_o && !flush_i; pop SHALL occur when id_valid_o && id_allowin_i && !flush_i.
REQ-016 if_allowin_o SHALL equal (count_o != DEPTH), independent of id_allowin_i (no full-push-while-pop).
REQ-017 id_valid_o SHALL equal (count_o != 0); head fields SHALL be driven 0 while empty.
REQ-018 Entry pushed in cycle N SHALL appear at id outputs in cycle N+1 (when it is head); order strictly FIFO.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-020 Pointers SHALL wrap modulo DEPTH; count SHALL saturate-free track 0..DEPTH exactly.
REQ-021 flush_i SHALL have priority: next cycle count=0, both pointers=0, any same-cycle push and pop discarded.
REQ-022 Push while full or pop while empty SHALL be impossible by construction (no state change).
REQ-023 id_* outputs SHALL remain stable while id_valid_o && !id_allowin_i && !flush_i.

Reset
REQ-024 On rst_n low, asynchronously: pointers=0, count_o=0, id_valid_o=0, id_pc_o/id_inst_o/id_excp_o=0, if_allowin_o=1 once reset deasserts.
REQ-025 Storage array contents SHALL NOT require reset; outputs remain 0 via the empty-mux.
REQ-026 Reset asserted mid-operation SHALL discard all entries identically to flush.

Configuration
REQ-027 Macro IQ_BYPASS_EN, when defined, SHALL pass an offered entry straight to id_* in the same cycle when queue empty, if_valid_i && id_allowin_i && !flush_i; entry not stored, count unchanged, id_valid_o=1 that cycle.
REQ-028 Without IQ_BYPASS_EN, REQ-018 one-cycle minimum latency SHALL apply unconditionally and id_valid_o SHALL be purely a function of registered state.

Structure
REQ-029 Bus widths (PC 32, inst 32, excp 7) and the packed IF-to-queue / queue-to-ID bus widths SHALL be defined in the shared DefineModuleBus.h header, not locally.
REQ-030 Pointer/count logic SHALL be one sub-module iq_ptr_ctrl (inputs push, pop, flush; outputs rd_ptr, wr_ptr, count); storage and output mux stay in the top.

Verification
REQ-031 Reset, then push PCs 0x1C000000,0x1C000004,0x1C000008,0x1C00000C with id_allowin_i=0 -> count_o=4, if_allowin_o=0, id_pc_o=0x1C000000.
REQ-032 From full, id_allowin_i=1 four cycles, if_valid_i=0 -> id_pc_o sequence 0x1C000000..0x1C00000C, then id_valid_o=0, id fields 0.
REQ-033 Count=2, push and pop same cycle for 10 cycles -> count_o stays 2, pointers wrap, order preserved.
REQ-034 Count=3, flush_i=1 with if_valid_i=1 and id_allowin_i=1 -> next cycle count_o=0, id_valid_o=0, offered entry lost.
REQ-035 Empty, if_valid_i=1 inst 0x02800000, id_allowin_i=1 -> with IQ_BYPASS_EN id_valid_o=1 same cycle, count_o=0; without, id_valid_o=1 next cycle.
REQ-036 rst_n pulsed low mid-stream at count=3 -> outputs 0 immediately, count_o=0 after release.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared bus widths and entry layout for the instruction fetch queue.
// Both the IF-to-queue and queue-to-ID buses carry {pc, inst, excp}.
package inst_fetch_queue_pkg;

  localparam int unsigned PcW    = 32;
  localparam int unsigned InstW  = 32;
  localparam int unsigned ExcpW  = 7;
  localparam int unsigned IfBusW = PcW + InstW + ExcpW;
  localparam int unsigned IdBusW = PcW + InstW + ExcpW;

  typedef struct packed {
    logic [PcW-1:0]   pc;
    logic [InstW-1:0] inst;
    logic [ExcpW-1:0] excp;
  } iq_entry_t;

endpackage

// File: rtl/iq_ptr_ctrl.sv
// Read/write pointers and occupancy counter for the fetch queue.
// Flush clears everything and wins over any same-cycle push or pop.
module iq_ptr_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W:0]   count_o
);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  // Guard against push-when-full and pop-when-empty regardless of the caller.
  assign push_ok = push_i && (count_q != (PTR_W+1)'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_ptr_o = rd_ptr_q;
  assign wr_ptr_o = wr_ptr_q;
  assign count_o  = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between IF and ID: DEPTH-entry FIFO of {pc, inst, excp}.
// Define IQ_BYPASS_EN to forward an offered entry straight to ID when the queue is empty.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             if_valid_i,
  input  logic [PcW-1:0]   if_pc_i,
  input  logic [InstW-1:0] if_inst_i,
  input  logic [ExcpW-1:0] if_excp_i,
  output logic             if_allowin_o,
  output logic             id_valid_o,
  input  logic             id_allowin_i,
  output logic [PcW-1:0]   id_pc_o,
  output logic [InstW-1:0] id_inst_o,
  output logic [ExcpW-1:0] id_excp_o,
  output logic [PTR_W:0]   count_o
);

  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    count;
  logic              q_empty, q_full;
  logic              push, pop, bypass;
  logic [IfBusW-1:0] if_bus;
  logic [IdBusW-1:0] id_bus;
  iq_entry_t         mem [DEPTH];

  assign if_bus  = {if_pc_i, if_inst_i, if_excp_i};
  assign q_empty = (count == '0);
  assign q_full  = (count == (PTR_W+1)'(DEPTH));

  assign if_allowin_o = !q_full;

`ifdef IQ_BYPASS_EN
  assign bypass = q_empty && if_valid_i && id_allowin_i && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry is consumed by ID directly and never enters storage.
  assign push = if_valid_i && if_allowin_o && !flush_i && !bypass;
  assign pop  = !q_empty && id_allowin_i && !flush_i;

  iq_ptr_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ptr_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_i   (push),
    .pop_i    (pop),
    .flush_i  (flush_i),
    .rd_ptr_o (rd_ptr),
    .wr_ptr_o (wr_ptr),
    .count_o  (count)
  );

  // Storage is not reset; the empty-mux below keeps outputs clean.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= iq_entry_t'(if_bus);
  end

  always_comb begin
    id_bus = '0;
    if (!q_empty) begin
      id_bus = mem[rd_ptr];
    end else if (bypass) begin
      id_bus = if_bus;
    end
  end

  assign id_valid_o                      = !q_empty || bypass;
  assign {id_pc_o, id_inst_o, id_excp_o} = id_bus;
  assign count_o                         = count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: fill/drain, steady push+pop, flush, bypass, async reset.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        if_valid_i = 1'b0;
  logic [31:0] if_pc_i = '0;
  logic [31:0] if_inst_i = '0;
  logic [6:0]  if_excp_i = '0;
  logic        id_allowin_i = 1'b0;
  logic        if_allowin_o;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic [6:0]  id_excp_o;
  logic [2:0]  count_o;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] BaseA = 32'h1C00_0000;
  localparam logic [31:0] BaseB = 32'h1C00_1000;

  inst_fetch_queue #(
    .DEPTH (4),
    .PTR_W (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .if_valid_i   (if_valid_i),
    .if_pc_i      (if_pc_i),
    .if_inst_i    (if_inst_i),
    .if_excp_i    (if_excp_i),
    .if_allowin_o (if_allowin_o),
    .id_valid_o   (id_valid_o),
    .id_allowin_i (id_allowin_i),
    .id_pc_o      (id_pc_o),
    .id_inst_o    (id_inst_o),
    .id_excp_o    (id_excp_o),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [6:0] excp_of(input logic [31:0] pc);
    return pc[8:2];
  endfunction

  task automatic offer(input logic [31:0] pc);
    if_valid_i = 1'b1;
    if_pc_i    = pc;
    if_inst_i  = inst_of(pc);
    if_excp_i  = excp_of(pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    check_eq("rst_valid", 32'(id_valid_o), 32'd0);
    check_eq("rst_count", 32'(count_o), 32'd0);
    check_eq("rst_pc", id_pc_o, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    check_eq("rst_allowin", 32'(if_allowin_o), 32'd1);

    // Fill to full with decode stalled
    for (int i = 0; i < 4; i++) begin
      offer(BaseA + 32'(4 * i));
      step();
      if (i == 0) begin
        check_eq("first_latency_valid", 32'(id_valid_o), 32'd1);
        check_eq("first_latency_pc", id_pc_o, BaseA);
      end
    end
    #1;
    check_eq("full_count", 32'(count_o), 32'd4);
    check_eq("full_allowin", 32'(if_allowin_o), 32'd0);
    check_eq("full_head_pc", id_pc_o, BaseA);
    // Offer while full: no state change, head stable
    offer(32'h1C00_0F00);
    step();
    step();
    check_eq("full_push_count", 32'(count_o), 32'd4);
    check_eq("stall_stable_pc", id_pc_o, BaseA);
    check_eq("stall_stable_inst", id_inst_o, inst_of(BaseA));

    // Drain in order
    if_valid_i   = 1'b0;
    id_allowin_i = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_pc", id_pc_o, BaseA + 32'(4 * i));
      check_eq("drain_excp", 32'(id_excp_o), 32'(excp_of(BaseA + 32'(4 * i))));
      step();
    end
    check_eq("empty_valid", 32'(id_valid_o), 32'd0);
    check_eq("empty_pc", id_pc_o, 32'd0);
    check_eq("empty_inst", id_inst_o, 32'd0);
    check_eq("empty_excp", 32'(id_excp_o), 32'd0);
    step();
    check_eq("pop_empty_count", 32'(count_o), 32'd0);

    // Steady push+pop at count 2 across pointer wrap
    id_allowin_i = 1'b0;
    offer(BaseB);
    step();
    offer(BaseB + 32'd4);
    step();
    check_eq("pp_start_count", 32'(count_o), 32'd2);
    id_allowin_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(BaseB + 32'(4 * (i + 2)));
      #1;
      check_eq("pp_head_pc", id_pc_o, BaseB + 32'(4 * i));
      step();
      check_eq("pp_count", 32'(count_o), 32'd2);
    end

    // Flush at count 3 discards the same-cycle offer and pop
    id_allowin_i = 1'b0;
    offer(BaseB + 32'd48);
    step();
    if_valid_i = 1'b0;
    #1;
    check_eq("preflush_count", 32'(count_o), 32'd3);
    check_eq("preflush_head", id_pc_o, BaseB + 32'd40);
    flush_i      = 1'b1;
    id_allowin_i = 1'b1;
    offer(32'h1C00_0BAD);
    step();
    flush_i      = 1'b0;
    if_valid_i   = 1'b0;
    id_allowin_i = 1'b0;
    #1;
    check_eq("flush_count", 32'(count_o), 32'd0);
    check_eq("flush_valid", 32'(id_valid_o), 32'd0);
    offer(BaseB + 32'h100);
    step();
    if_valid_i = 1'b0;
    #1;
    check_eq("postflush_head", id_pc_o, BaseB + 32'h100);
    check_eq("postflush_count", 32'(count_o), 32'd1);
    id_allowin_i = 1'b1;
    step();
    check_eq("postflush_drain", 32'(count_o), 32'd0);

    // Empty queue, offer with decode ready
    offer(32'h1C00_2000);
    if_inst_i = 32'h0280_0000;
    #1;
`ifdef IQ_BYPASS_EN
    check_eq("byp_same_valid", 32'(id_valid_o), 32'd1);
    check_eq("byp_same_inst", id_inst_o, 32'h0280_0000);
    check_eq("byp_same_count", 32'(count_o), 32'd0);
    step();
    if_valid_i = 1'b0;
    #1;
    check_eq("byp_next_valid", 32'(id_valid_o), 32'd0);
    check_eq("byp_next_count", 32'(count_o), 32'd0);
`else
    check_eq("nobyp_same_valid", 32'(id_valid_o), 32'd0);
    step();
    if_valid_i = 1'b0;
    #1;
    check_eq("nobyp_next_valid", 32'(id_valid_o), 32'd1);
    check_eq("nobyp_next_inst", id_inst_o, 32'h0280_0000);
    check_eq("nobyp_next_count", 32'(count_o), 32'd1);
    step();
    check_eq("nobyp_drain", 32'(count_o), 32'd0);
`endif

    // Asynchronous reset mid-stream at count 3
    id_allowin_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(BaseA + 32'h40 + 32'(4 * i));
      step();
    end
    if_valid_i = 1'b0;
    #1;
    check_eq("prerst_count", 32'(count_o), 32'd3);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(id_valid_o), 32'd0);
    check_eq("midrst_pc", id_pc_o, 32'd0);
    check_eq("midrst_count", 32'(count_o), 32'd0);
    #2 rst_n = 1'b1;
    step();
    check_eq("postrst_count", 32'(count_o), 32'd0);
    check_eq("postrst_allowin", 32'(if_allowin_o), 32'd1);
    offer(BaseA + 32'h80);
    step();
    if_valid_i = 1'b0;
    #1;
    check_eq("postrst_head", id_pc_o, BaseA + 32'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
